// File: rtl/incubator_plant_if.sv
// Controller <-> plant bundle: actuator drives in, sensor feedback out.
interface incubator_plant_if;
    logic              heater;
    logic              cooler;
    logic [3:0]        CRS;
    logic signed [7:0] sensor;
    logic              sample;
    logic              fault;

    modport master (output heater, cooler, CRS, input sensor, sample, fault);
    modport slave  (input heater, cooler, CRS, output sensor, sample, fault);
endinterface

// File: rtl/incubator_plant.sv
// Thermal plant model: ticked temperature update with heat/cool/drift and sticky fault.
// Optional sensor noise LFSR enabled by defining PLANT_NOISE_EN.
module incubator_plant #(
    parameter logic signed [7:0] T_INIT    = 8'sd25,
    parameter logic signed [7:0] T_AMB     = 8'sd25,
    parameter int unsigned       TICK_DIV  = 16,
    parameter int unsigned       HEAT_STEP = 2,
    parameter int unsigned       DRIFT_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    incubator_plant_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;
    localparam logic signed [9:0] HSTEP = 10'(HEAT_STEP);

    typedef enum logic [1:0] {DRIFT, HEAT, COOL, FAULT} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     tcnt;
    logic [DW-1:0]     dcnt, dcnt_n;
    logic signed [7:0] temp, temp_n, sens_n, sensor_q;
    logic signed [9:0] t_ext, sum;
    logic              tick, sample_q, both;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127)       return 8'sd127;
        else if (v < -10'sd128) return -8'sd128;
        else                    return v[7:0];
    endfunction

    assign tick  = (tcnt == CW'(TICK_DIV - 1));
    assign both  = bus.heater & bus.cooler;
    assign t_ext = 10'(temp);

    // Fault entry is immediate; every other transition waits for a tick.
    always_comb begin
        state_n = state;
        if (both)
            state_n = FAULT;
        else if (tick && state != FAULT) begin
            case ({bus.heater, bus.cooler})
                2'b10:   state_n = HEAT;
                2'b01:   state_n = COOL;
                default: state_n = DRIFT;
            endcase
        end
    end

    // Temperature step keys off state_n so the tick-cycle inputs act without lag.
    always_comb begin
        dcnt_n = dcnt;
        sum    = t_ext;
        if (tick) begin
            case (state_n)
                HEAT: begin
                    sum    = t_ext + HSTEP;
                    dcnt_n = '0;
                end
                COOL: begin
                    sum    = t_ext - 10'sd1 - $signed({8'b0, bus.CRS[3:2]});
                    dcnt_n = '0;
                end
                DRIFT: begin
                    if (dcnt == DW'(DRIFT_DIV - 1)) begin
                        dcnt_n = '0;
                        if (temp < T_AMB)      sum = t_ext + 10'sd1;
                        else if (temp > T_AMB) sum = t_ext - 10'sd1;
                    end else begin
                        dcnt_n = dcnt + DW'(1);
                    end
                end
                default: dcnt_n = '0;
            endcase
        end
        temp_n = sat8(sum);
    end

`ifdef PLANT_NOISE_EN
    logic [7:0]        lfsr, lfsr_n;
    logic signed [9:0] noise;

    always_comb begin
        lfsr_n = tick ? {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]} : lfsr;
        if (lfsr_n[0] & ~lfsr_n[1])      noise = 10'sd1;
        else if (lfsr_n[1] & ~lfsr_n[0]) noise = -10'sd1;
        else                             noise = 10'sd0;
        sens_n = sat8(10'(temp_n) + noise);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr <= 8'hA5;
        else       lfsr <= lfsr_n;
    end
`else
    assign sens_n = temp_n;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= DRIFT;
        else       state <= state_n;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt     <= '0;
            dcnt     <= '0;
            temp     <= T_INIT;
            sensor_q <= T_INIT;
            sample_q <= 1'b0;
        end else begin
            tcnt     <= tick ? '0 : tcnt + CW'(1);
            dcnt     <= dcnt_n;
            temp     <= temp_n;
            sample_q <= tick;
            if (tick) sensor_q <= sens_n;
        end
    end

    assign bus.sensor = sensor_q;
    assign bus.sample = sample_q;
    assign bus.fault  = (state == FAULT);
endmodule

// File: doc/incubator_plant.md
INCUBATOR_PLANT -- requirements
Module: incubator_plant

Interface
REQ-001 Parameter T_INIT, default 25: signed 8-bit initial chamber temperature in degrees C.
REQ-002 Parameter T_AMB, default 25: signed 8-bit ambient temperature that the chamber drifts toward.
REQ-003 Parameter TICK_DIV, default 16: clock cycles per plant update tick; range 2 to 65535.
REQ-004 Parameter HEAT_STEP, default 2: temperature increase per tick while heating; range 1 to 15.
REQ-005 Parameter DRIFT_DIV, default 4: ticks per 1-degree drift step; range 1 to 255.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 rstn  input  1  reset, asynchronous and active-low.
REQ-008 heater  input  1  heater drive from the climate controller.
REQ-009 cooler  input  1  cooler drive from the climate controller.
REQ-010 CRS  input  4  fan speed code; 0 is off and 15 is maximum.
REQ-011 sensor  output  8  signed two's-complement temperature reading fed back to the controller.
REQ-012 sample  output  1  one-cycle pulse marking each sensor update.
REQ-013 fault  output  1  sticky flag meaning heater and cooler were driven at the same time.

Function
REQ-014 A tick counter SHALL count 0 to TICK_DIV-1 and wrap to 0; a tick occurs in the cycle where the count equals TICK_DIV-1.
REQ-015 The FSM SHALL have the states DRIFT, HEAT, COOL and FAULT; state updates happen on ticks only, except the entry into FAULT.
REQ-016 On a tick, the next state SHALL be chosen from the inputs: heater=1 with cooler=0 gives HEAT; cooler=1 with heater=0 gives COOL; both 0 gives DRIFT.
REQ-017 In any cycle, tick or not, with heater=1 and cooler=1, the next state SHALL be FAULT and fault SHALL be 1 from the next cycle.
REQ-018 FAULT SHALL be left only by reset; in FAULT the internal temperature is frozen, and sample and the sensor keep updating on ticks.
REQ-019 On a HEAT tick, temp SHALL become temp + HEAT_STEP.
REQ-020 On a COOL tick, temp SHALL become temp - (1 + CRS[3:2]), giving a step of 1 to 4.
REQ-021 The temperature change SHALL use the inputs sampled in the tick cycle itself, with no state-lag.
REQ-022 In DRIFT, a drift counter SHALL count ticks; every DRIFT_DIV-th tick, temp moves 1 degree toward T_AMB and holds if equal.
REQ-023 The drift counter SHALL clear whenever a tick selects HEAT, COOL or FAULT.
REQ-024 Arithmetic SHALL be performed at 10-bit signed width, with the result saturated to the range -128 to +127 and never wrapping.
REQ-025 sensor and sample SHALL be registered; sensor reflects the post-tick temp exactly one cycle after the tick, with sample=1 in that same cycle.

Reset
REQ-026 While rstn=0, the following SHALL hold: temp=T_INIT, sensor=T_INIT, sample=0, fault=0, state DRIFT, tick and drift counters 0, LFSR=8'hA5.
REQ-027 Reset asserted mid-tick or in FAULT SHALL take effect immediately, and the first tick after release SHALL come TICK_DIV cycles after release.

Configuration
REQ-028 Macro PLANT_NOISE_EN: when defined, an 8-bit LFSR with polynomial x^8+x^6+x^5+x^4+1 SHALL advance once per tick.
REQ-029 With PLANT_NOISE_EN defined, the sensor SHALL equal saturate(temp + d), where d=+1 if lfsr[0]&~lfsr[1], d=-1 if lfsr[1]&~lfsr[0], and d=0 otherwise; the internal temp is unaffected by d.
REQ-030 Without PLANT_NOISE_EN, no LFSR SHALL exist and sensor SHALL equal temp exactly.

Verification
REQ-031 The bench SHALL use TICK_DIV=4 and DRIFT_DIV=2 without PLANT_NOISE_EN, with other parameters at their defaults unless a scenario states otherwise.
REQ-032 Scenario "reset": hold rstn=0 -> sensor=25, fault=0, sample=0; after release, the first sample pulse is at cycle 5.
REQ-033 Scenario "heat": heater=1 for 5 ticks from 25 -> sensor reads 27, 29, 31, 33, 35, each one cycle after its tick.
REQ-034 Scenario "cool": cooler=1, CRS=15 for 3 ticks from 25 -> sensor reads 21, 17, 13; then with CRS=3 for 1 tick -> sensor reads 12.
REQ-035 Scenario "saturate and drift": with T_INIT=120 and heater=1 for 10 ticks -> sensor reaches 127 and holds; with T_INIT=30 and both inputs 0 -> sensor reaches 25 after 10 ticks, then holds.
REQ-036 Scenario "fault": heater=1 and cooler=1 for 1 non-tick cycle -> fault=1 next cycle and sensor frozen through 5 further ticks of heater=1; a rstn pulse then clears fault and sets sensor=25.
